// File: rtl/ram_arbiter.sv
// ---------------------------------------------------------------------------
// ram_arbiter
//   Shares one single-port synchronous RAM between two requesters (A and B).
//   At most one access is granted per cycle. Ties in the idle state go to the
//   side that was not granted last (round-robin). A requester can lock the
//   RAM for back-to-back accesses. The lock is dropped when the owner
//   deasserts its lock while idle, or after LOCK_MAX consecutive idle cycles.
//
// Ports
//   i_clk, i_rst_n            clock, synchronous active-low reset
//   i_x_req/we/lock/addr/data requester x (a or b) access request
//   o_x_gnt                   combinational grant; access executes at next posedge
//   o_x_rvalid / o_x_rdata    read return, one cycle after a granted read
//   o_ram_addr/data/we/re     RAM command port
//   i_ram_data                RAM registered read data
// ---------------------------------------------------------------------------
module ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 8,
    parameter int LOCK_MAX   = 15
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic                  i_a_req,
    input  logic                  i_a_we,
    input  logic                  i_a_lock,
    input  logic [ADDR_WIDTH-1:0] i_a_addr,
    input  logic [DATA_WIDTH-1:0] i_a_data,
    input  logic                  i_b_req,
    input  logic                  i_b_we,
    input  logic                  i_b_lock,
    input  logic [ADDR_WIDTH-1:0] i_b_addr,
    input  logic [DATA_WIDTH-1:0] i_b_data,
    output logic                  o_a_gnt,
    output logic                  o_b_gnt,
    output logic                  o_a_rvalid,
    output logic                  o_b_rvalid,
    output logic [DATA_WIDTH-1:0] o_a_rdata,
    output logic [DATA_WIDTH-1:0] o_b_rdata,
    output logic [ADDR_WIDTH-1:0] o_ram_addr,
    output logic [DATA_WIDTH-1:0] o_ram_data,
    output logic                  o_ram_we,
    output logic                  o_ram_re,
    input  logic [DATA_WIDTH-1:0] i_ram_data
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOCK_A = 2'd1,
        ST_LOCK_B = 2'd2
    } state_e;

    // Counter value on which the last allowed idle cycle of a lock ends.
    localparam logic [7:0] LOCK_LAST = 8'(LOCK_MAX - 1);

    state_e     state_q, state_d;
    logic       last_b_q, last_b_d;     // 1: B was granted most recently
    logic [7:0] cnt_q, cnt_d;           // consecutive idle cycles while locked
    logic       a_rvalid_q, a_rvalid_d;
    logic       b_rvalid_q, b_rvalid_d;
    logic       gnt_a_s, gnt_b_s;

    // Grant decision; reset forces both grants low immediately.
    always_comb begin
        gnt_a_s = 1'b0;
        gnt_b_s = 1'b0;
        if (!i_rst_n) begin
            gnt_a_s = 1'b0;
            gnt_b_s = 1'b0;
        end else begin
            case (state_q)
                ST_LOCK_A: gnt_a_s = i_a_req;
                ST_LOCK_B: gnt_b_s = i_b_req;
                default: begin
                    // Idle (and any unreachable encoding): round-robin on ties.
                    if (i_a_req && i_b_req) begin
                        if (last_b_q) begin
                            gnt_a_s = 1'b1;
                        end else begin
                            gnt_b_s = 1'b1;
                        end
                    end else begin
                        gnt_a_s = i_a_req;
                        gnt_b_s = i_b_req;
                    end
                end
            endcase
        end
    end

    // Next-state logic for ownership, round-robin pointer, lock counter, rvalid.
    always_comb begin
        state_d    = state_q;
        last_b_d   = last_b_q;
        cnt_d      = cnt_q;
        a_rvalid_d = gnt_a_s & ~i_a_we;
        b_rvalid_d = gnt_b_s & ~i_b_we;
        if (gnt_a_s) begin
            last_b_d = 1'b0;
            cnt_d    = 8'd0;
            state_d  = i_a_lock ? ST_LOCK_A : ST_IDLE;
        end else if (gnt_b_s) begin
            last_b_d = 1'b1;
            cnt_d    = 8'd0;
            state_d  = i_b_lock ? ST_LOCK_B : ST_IDLE;
        end else begin
            case (state_q)
                ST_LOCK_A: begin
                    if (!i_a_lock || (cnt_q == LOCK_LAST)) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_LOCK_B: begin
                    if (!i_b_lock || (cnt_q == LOCK_LAST)) begin
                        state_d = ST_IDLE;
                        cnt_d   = 8'd0;
                    end else begin
                        cnt_d = cnt_q + 8'd1;
                    end
                end
                ST_IDLE: begin
                    cnt_d = 8'd0;
                end
                default: begin
                    state_d = ST_IDLE;
                    cnt_d   = 8'd0;
                end
            endcase
        end
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            state_q    <= ST_IDLE;
            last_b_q   <= 1'b1;
            cnt_q      <= 8'd0;
            a_rvalid_q <= 1'b0;
            b_rvalid_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_b_q   <= last_b_d;
            cnt_q      <= cnt_d;
            a_rvalid_q <= a_rvalid_d;
            b_rvalid_q <= b_rvalid_d;
        end
    end

    // RAM command mux: granted side drives the port, otherwise all zero.
    always_comb begin
        o_ram_addr = {ADDR_WIDTH{1'b0}};
        o_ram_data = {DATA_WIDTH{1'b0}};
        o_ram_we   = 1'b0;
        o_ram_re   = 1'b0;
        if (gnt_a_s) begin
            o_ram_addr = i_a_addr;
            o_ram_data = i_a_data;
            o_ram_we   = i_a_we;
            o_ram_re   = ~i_a_we;
        end else if (gnt_b_s) begin
            o_ram_addr = i_b_addr;
            o_ram_data = i_b_data;
            o_ram_we   = i_b_we;
            o_ram_re   = ~i_b_we;
        end else begin
            o_ram_addr = {ADDR_WIDTH{1'b0}};
            o_ram_data = {DATA_WIDTH{1'b0}};
            o_ram_we   = 1'b0;
            o_ram_re   = 1'b0;
        end
    end

    assign o_a_gnt    = gnt_a_s;
    assign o_b_gnt    = gnt_b_s;
    assign o_a_rvalid = a_rvalid_q;
    assign o_b_rvalid = b_rvalid_q;
    // RAM output is shared, so each side only sees it on its own rvalid cycle.
    assign o_a_rdata  = a_rvalid_q ? i_ram_data : {DATA_WIDTH{1'b0}};
    assign o_b_rdata  = b_rvalid_q ? i_ram_data : {DATA_WIDTH{1'b0}};

endmodule

// File: tb/tb_ram_arbiter.sv
module tb_ram_arbiter;
    localparam int AW       = 8;
    localparam int DW       = 8;
    localparam int LOCK_MAX = 15;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst_n;
    logic          a_req, a_we, a_lock, b_req, b_we, b_lock;
    logic [AW-1:0] a_addr, b_addr;
    logic [DW-1:0] a_data, b_data;
    logic          a_gnt, b_gnt, a_rvalid, b_rvalid;
    logic [DW-1:0] a_rdata, b_rdata;
    logic [AW-1:0] ram_addr;
    logic [DW-1:0] ram_wdata, ram_q;
    logic          ram_we, ram_re;

    ram_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .LOCK_MAX(LOCK_MAX)) dut (
        .i_clk(clk), .i_rst_n(rst_n),
        .i_a_req(a_req), .i_a_we(a_we), .i_a_lock(a_lock), .i_a_addr(a_addr), .i_a_data(a_data),
        .i_b_req(b_req), .i_b_we(b_we), .i_b_lock(b_lock), .i_b_addr(b_addr), .i_b_data(b_data),
        .o_a_gnt(a_gnt), .o_b_gnt(b_gnt), .o_a_rvalid(a_rvalid), .o_b_rvalid(b_rvalid),
        .o_a_rdata(a_rdata), .o_b_rdata(b_rdata),
        .o_ram_addr(ram_addr), .o_ram_data(ram_wdata), .o_ram_we(ram_we), .o_ram_re(ram_re),
        .i_ram_data(ram_q)
    );

    // Single-port RAM with registered read.
    logic [DW-1:0] ram_mem [0:255];
    always @(posedge clk) begin
        if (ram_we) ram_mem[ram_addr] <= ram_wdata;
        if (ram_re) ram_q <= ram_mem[ram_addr];
    end

    // Reference model: who holds the lock, how long it has idled, who won last.
    int            owner;      // -1 none, 0 A, 1 B
    int            idle;
    int            last;       // 0 A, 1 B
    logic [DW-1:0] ref_mem [0:255];

    typedef struct {
        int            cyc;
        logic [DW-1:0] data;
    } exp_t;
    exp_t qa[$];
    exp_t qb[$];

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic set_a(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        a_req = req; a_we = we; a_lock = lock; a_addr = addr; a_data = data;
    endtask

    task automatic set_b(input logic req, input logic we, input logic lock,
                         input logic [AW-1:0] addr, input logic [DW-1:0] data);
        b_req = req; b_we = we; b_lock = lock; b_addr = addr; b_data = data;
    endtask

    // Check grants and RAM command for the current inputs, then advance the model.
    task automatic drive_cycle();
        int            g;
        logic          lk;
        logic [AW-1:0] eaddr;
        logic [DW-1:0] edata;
        logic          ewe, ere;
        exp_t          e;
        @(negedge clk);
        g = -1;
        if (rst_n) begin
            if (owner == 0)      g = a_req ? 0 : -1;
            else if (owner == 1) g = b_req ? 1 : -1;
            else if (a_req && b_req) g = (last == 0) ? 1 : 0;
            else if (a_req)      g = 0;
            else if (b_req)      g = 1;
        end
        eaddr = '0; edata = '0; ewe = 1'b0; ere = 1'b0;
        if (g == 0) begin
            eaddr = a_addr; edata = a_data; ewe = a_we; ere = ~a_we;
        end else if (g == 1) begin
            eaddr = b_addr; edata = b_data; ewe = b_we; ere = ~b_we;
        end
        check("gnt_a", 32'(a_gnt), 32'(g == 0));
        check("gnt_b", 32'(b_gnt), 32'(g == 1));
        check("ram_addr", 32'(ram_addr), 32'(eaddr));
        check("ram_data", 32'(ram_wdata), 32'(edata));
        check("ram_we", 32'(ram_we), 32'(ewe));
        check("ram_re", 32'(ram_re), 32'(ere));
        if (!rst_n) begin
            owner = -1; last = 1; idle = 0;
        end else if (g >= 0) begin
            last = g;
            idle = 0;
            lk = (g == 0) ? a_lock : b_lock;
            owner = lk ? g : -1;
            if (ewe) begin
                ref_mem[eaddr] = edata;
            end else begin
                e.cyc  = cyc + 1;
                e.data = ref_mem[eaddr];
                if (g == 0) qa.push_back(e); else qb.push_back(e);
            end
        end else if (owner >= 0) begin
            lk = (owner == 0) ? a_lock : b_lock;
            if (!lk) begin
                owner = -1; idle = 0;
            end else begin
                idle++;
                if (idle == LOCK_MAX) begin
                    owner = -1; idle = 0;
                end
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle_inputs();
        set_a(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        set_b(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 1'b0;
        drive_cycle();
        rst_n = 1'b1;
    endtask

    // Monitor: read returns must appear exactly on the predicted cycle.
    initial begin : monitor
        logic ea, eb;
        forever begin
            @(negedge clk);
            ea = (qa.size() > 0) && (qa[0].cyc == cyc);
            eb = (qb.size() > 0) && (qb[0].cyc == cyc);
            check("a_rvalid", 32'(a_rvalid), 32'(ea));
            check("b_rvalid", 32'(b_rvalid), 32'(eb));
            if (ea) begin
                check("a_rdata", 32'(a_rdata), 32'(qa[0].data));
                void'(qa.pop_front());
            end else begin
                check("a_rdata_zero", 32'(a_rdata), 32'd0);
            end
            if (eb) begin
                check("b_rdata", 32'(b_rdata), 32'(qb[0].data));
                void'(qb.pop_front());
            end else begin
                check("b_rdata_zero", 32'(b_rdata), 32'd0);
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not end, errors %0d", errors);
        $fatal(1);
    end

    initial begin : stimulus
        for (int i = 0; i < 256; i++) begin
            ram_mem[i] = '0;
            ref_mem[i] = '0;
        end
        ram_q = '0;
        owner = -1; idle = 0; last = 1;
        idle_inputs();
        rst_n = 1'b0;

        // Reset, then A writes 3 = 11 and reads it back.
        drive_cycle();
        drive_cycle();
        rst_n = 1'b1;
        set_a(1'b1, 1'b1, 1'b0, 8'd3, 8'd11);
        drive_cycle();
        set_a(1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
        drive_cycle();
        idle_inputs();
        drive_cycle();
        drive_cycle();

        // Both read continuously: grants alternate A,B,A,B.
        do_reset();
        set_a(1'b1, 1'b0, 1'b0, 8'd3, 8'd0);
        set_b(1'b1, 1'b0, 1'b0, 8'd6, 8'd0);
        repeat (4) drive_cycle();
        idle_inputs();
        drive_cycle();

        // A locks across two idle cycles, then writes 6 = 44; B then reads 44.
        do_reset();
        set_a(1'b1, 1'b0, 1'b1, 8'd6, 8'd0);
        set_b(1'b1, 1'b0, 1'b0, 8'd6, 8'd0);
        drive_cycle();
        set_a(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        repeat (2) drive_cycle();
        set_a(1'b1, 1'b1, 1'b0, 8'd6, 8'd44);
        drive_cycle();
        set_a(1'b0, 1'b0, 1'b0, 8'd0, 8'd0);
        drive_cycle();
        idle_inputs();
        repeat (2) drive_cycle();

        // Abandoned lock: B is held off for LOCK_MAX idle cycles, then granted.
        do_reset();
        set_a(1'b1, 1'b0, 1'b1, 8'd8, 8'd0);
        set_b(1'b1, 1'b1, 1'b0, 8'd9, 8'h55);
        drive_cycle();
        set_a(1'b0, 1'b0, 1'b1, 8'd0, 8'd0);
        repeat (LOCK_MAX + 1) drive_cycle();
        idle_inputs();
        repeat (2) drive_cycle();

        // Reset while B owns a lock and requests a read: no grant, no rvalid.
        do_reset();
        set_b(1'b1, 1'b1, 1'b1, 8'd5, 8'h77);
        drive_cycle();
        rst_n = 1'b0;
        set_b(1'b1, 1'b0, 1'b1, 8'd5, 8'd0);
        drive_cycle();
        rst_n = 1'b1;
        set_a(1'b1, 1'b0, 1'b0, 8'd5, 8'd0);
        set_b(1'b1, 1'b0, 1'b0, 8'd5, 8'd0);
        repeat (2) drive_cycle();
        idle_inputs();
        repeat (2) drive_cycle();

        // A fills addresses 1..9 with i*10, B reads them back.
        do_reset();
        for (int i = 1; i <= 9; i++) begin
            set_a(1'b1, 1'b1, 1'b0, 8'(i), 8'(i * 10));
            drive_cycle();
        end
        idle_inputs();
        for (int i = 1; i <= 9; i++) begin
            set_b(1'b1, 1'b0, 1'b0, 8'(i), 8'd0);
            drive_cycle();
        end
        idle_inputs();
        repeat (2) drive_cycle();

        // Random traffic with occasional resets and locks.
        do_reset();
        for (int n = 0; n < 400; n++) begin
            rst_n = ($urandom_range(0, 59) != 0);
            set_a($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)), 8'($urandom));
            set_b($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1,
                  $urandom_range(0, 3) == 0, 8'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 7) == 0) a_req = 1'b0;
            drive_cycle();
        end
        rst_n = 1'b1;
        idle_inputs();
        repeat (3) drive_cycle();

        check("a_queue_drained", 32'(qa.size()), 32'd0);
        check("b_queue_drained", 32'(qb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
